sort_collect: RTL and testbench
===============================

Name: sort_collect

Overview:
Upstream feeder for the sort stage. It accepts a byte stream with a valid/ready handshake and packs N consecutive bytes, or a shorter frame ended by i_last, into one packed N-element vector. It then pulses o_valid for one cycle, which drives the sort stage's i_data/i_valid directly. Unfilled slots in short frames are padded so that they sort to the end.

Parameters:
N, 8, elements per frame; N >= 2.
PAD_VAL, 8'hFF, value loaded into unfilled slots of a short frame.

Ports:
i_clk  input  1  clock.
i_rst  input  1  synchronous, active-high reset.
i_data  input  8  stream byte.
i_valid  input  1  i_data valid.
i_last  input  1  qualifies i_data as the final byte of a frame; meaningful only with i_valid.
o_ready  output  1  block can accept a byte this cycle.
o_data  output  [N-1:0][7:0]  packed frame; element 0 is the first byte accepted.
o_valid  output  1  one-cycle pulse; o_data and o_count are valid.
o_count  output  $clog2(N+1)  number of real (non-pad) elements in the frame.

Behaviour:
- Accept = i_valid && o_ready, sampled at posedge i_clk. If i_valid is high while o_ready is low, nothing happens; upstream holds the byte.
- Two states:
  - COLLECT: o_ready = 1.
  - EMIT: o_ready = 0, o_valid = 1.
- Index counter cnt, range 0..N-1, reset to 0.
- COLLECT, accept when cnt < N-1 and i_last = 0:
  - o_data[cnt] <= i_data
  - cnt <= cnt + 1
  - stay in COLLECT.
- COLLECT, accept when cnt == N-1 or i_last = 1 (final byte):
  - o_data[cnt] <= i_data
  - every slot above cnt <= PAD_VAL, on the same edge
  - o_count <= cnt + 1
  - cnt <= 0
  - go to EMIT.
- EMIT lasts exactly one cycle, then returns to COLLECT unconditionally.
- Latency: o_valid is high in the cycle after the final byte is accepted.
- Throughput: one dead cycle per frame. A full frame therefore takes N+1 cycles at 100% i_valid.
- o_data and o_count hold their values after EMIT until overwritten by the next frame's accepts. Consumers use them only while o_valid is high.
- Gaps in i_valid inside a frame are allowed; cnt holds through them.
- i_last together with cnt == N-1 is a normal full frame, with o_count = N.
- Reset, including mid-frame:
  - next state COLLECT, cnt = 0
  - o_data all 0, o_count 0, o_valid 0, o_ready 1 in the cycle after reset is sampled
  - any partial frame is discarded and no o_valid is produced for it
  - accepts are blocked while i_rst is high.
- Width rule: o_count is N for a full frame, so it is sized $clog2(N+1). The value N-1 must be representable in cnt.

Decomposition:
- Shared package sort_pkg:
  - DATA_W = 8
  - typedef logic [DATA_W-1:0] elem_t
  - typedef enum {COLLECT, EMIT} collect_state_t
  - default PAD_VAL constant.
- The sort stage uses elem_t from the same package.
- No sub-module; this is a single flat module.

Test Plan:
1. Hold i_rst for 2 cycles, then release -> o_valid = 0, o_ready = 1, o_data all 8'h00, o_count = 0.
2. Eight back-to-back bytes 8'h10..8'h17 with i_last = 0 -> o_valid is a single pulse in the cycle after the 8th accept, o_data[0..7] = 10..17, o_count = 8, and o_ready = 0 in that same cycle.
3. Bytes A0, A1, A2 with i_last on A2 -> o_data[0..2] = A0, A1, A2, o_data[3..7] = FF, o_count = 3, and o_valid pulses one cycle after A2.
4. Start the next frame's byte 8'h55 during the EMIT cycle and hold it -> not accepted in EMIT. It is accepted on the following cycle and lands in o_data[0] of the next frame.
5. Accept 5 bytes, pulse i_rst for 1 cycle, then send a full frame 8'h00..8'h07 -> no o_valid for the partial frame, and the next frame emits 00..07 with o_count = 8.
6. Send frame 10..17 with i_valid toggling 1,0,1,0 -> o_data and o_count are identical to scenario 2, and o_valid pulses exactly once.

Source files
------------

// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sort pipeline: the element width and type that
// both the collector and the sort stage agree on, the collector's state
// encoding, and the default pad byte. The pad byte is the largest element
// value, so unfilled slots in a short frame sort to the end.
// ---------------------------------------------------------------------------
package sort_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] elem_t;

  typedef enum logic {
    COLLECT,
    EMIT
  } collect_state_t;

  localparam elem_t PAD_VAL_DEFAULT = 8'hFF;

endpackage

// File: rtl/sort_collect.sv
// ---------------------------------------------------------------------------
// sort_collect
// Upstream feeder for the sort stage. Bytes arrive on a valid/ready stream
// and are packed into an N-element vector. A frame ends after N bytes or
// earlier on a byte flagged with i_last. Slots that a short frame did not
// fill are loaded with PAD_VAL. The finished frame is presented for exactly
// one cycle with o_valid. That cycle is also the one dead cycle per frame,
// because no byte is accepted while the frame is being emitted.
//
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_data   stream byte
//   i_valid  i_data is valid
//   i_last   i_data is the final byte of a frame (meaningful with i_valid)
//   o_ready  a byte can be accepted this cycle
//   o_data   packed frame; element 0 is the first byte accepted
//   o_valid  one-cycle pulse; o_data and o_count are valid
//   o_count  number of real (non-pad) elements in the frame
// ---------------------------------------------------------------------------
module sort_collect
  import sort_pkg::*;
#(
  parameter int    N       = 8,
  parameter elem_t PAD_VAL = PAD_VAL_DEFAULT
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [DATA_W-1:0]               i_data,
  input  logic                            i_valid,
  input  logic                            i_last,
  output logic                            o_ready,
  output logic [N-1:0][DATA_W-1:0]        o_data,
  output logic                            o_valid,
  output logic [$clog2(N+1)-1:0]          o_count
);

  // The index counter only needs to reach N-1. The count output must also
  // be able to hold N, so it gets its own wider width.
  localparam int CNT_W   = $clog2(N);
  localparam int COUNT_W = $clog2(N+1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N-1);

  collect_state_t               r_state;
  collect_state_t               w_nextState;
  logic [CNT_W-1:0]             r_cnt;
  logic [N-1:0][DATA_W-1:0]     r_data;
  logic [COUNT_W-1:0]           r_count;
  logic                         w_accept;
  logic                         w_final;

  // A byte is taken only while collecting. The byte closes the frame when it
  // fills the last slot or upstream marks it as the last one. A full frame
  // whose last byte also carries i_last is still an ordinary full frame.
  assign w_accept = i_valid && o_ready;
  assign w_final  = (r_cnt == LAST_IDX) || i_last;

  // Next-state and handshake outputs. EMIT always lasts a single cycle, so
  // o_valid is a clean one-cycle pulse and o_ready drops for that cycle.
  always_comb begin
    w_nextState = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      COLLECT: begin
        o_ready = 1'b1;
        if (w_accept && w_final) begin
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        o_valid     = 1'b1;
        w_nextState = COLLECT;
      end
      default: begin
        w_nextState = COLLECT;
      end
    endcase
  end

  // State, slot index and frame storage. On the closing byte, every slot
  // above the current index is padded on the same edge, so the emitted
  // vector never carries stale bytes from an earlier, longer frame. Reset
  // throws away any partial frame and clears the outputs. Because reset
  // takes priority here, bytes are never accepted while reset is high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= COLLECT;
      r_cnt   <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        if (w_final) begin
          for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) > r_cnt) begin
              r_data[i] <= PAD_VAL;
            end
          end
          r_data[r_cnt] <= i_data;
          r_count       <= COUNT_W'(r_cnt) + COUNT_W'(1);
          r_cnt         <= '0;
        end else begin
          r_data[r_cnt] <= i_data;
          r_cnt         <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: tb/tb_sort_collect.sv
// ---------------------------------------------------------------------------
// tb_sort_collect
// Directed scenarios followed by a randomized stream for sort_collect. The
// reference model treats a frame as a queue of accepted bytes. When the
// queue reaches N entries or takes a byte flagged last, it becomes the
// expected frame (queue contents followed by pad bytes), and that frame is
// expected on the cycle after the closing byte.
// ---------------------------------------------------------------------------
module tb_sort_collect;
  import sort_pkg::*;

  localparam int N = 8;
  localparam int COUNT_W = $clog2(N+1);

  logic                       clk;
  logic                       i_rst;
  logic [7:0]                 i_data;
  logic                       i_valid;
  logic                       i_last;
  logic                       o_ready;
  logic [N-1:0][7:0]          o_data;
  logic                       o_valid;
  logic [COUNT_W-1:0]         o_count;

  int total;
  int bad;

  // Reference model state
  logic [7:0]                 frameQ[$];
  logic                       modelEmit;
  logic                       modelReady;
  logic                       dataIsZero;
  logic [N-1:0][7:0]          expData;
  logic [COUNT_W-1:0]         expCount;

  sort_collect #(
    .N       (N),
    .PAD_VAL (8'hFF)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_count (o_count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and advance the model past the clock edge.
  // Inputs change and outputs are sampled 1 unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic valid,
                               input logic last, input logic [7:0] data);
    logic accept;
    i_rst   = rst;
    i_valid = valid;
    i_last  = last;
    i_data  = data;
    accept  = valid && modelReady && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      frameQ.delete();
      modelEmit  = 1'b0;
      modelReady = 1'b1;
      expData    = '0;
      expCount   = '0;
      dataIsZero = 1'b1;
    end else begin
      modelEmit = 1'b0;
      if (accept) begin
        frameQ.push_back(data);
        dataIsZero = 1'b0;
        if (last || frameQ.size() == N) begin
          for (int i = 0; i < N; i++) begin
            expData[i] = (i < frameQ.size()) ? frameQ[i] : 8'hFF;
          end
          expCount = COUNT_W'(frameQ.size());
          frameQ.delete();
          modelEmit = 1'b1;
        end
      end
      modelReady = !modelEmit;
    end
  endtask

  // Compare the handshake every cycle. Compare the frame contents whenever
  // a frame is expected, and whenever the reset-cleared values must still
  // be visible.
  task automatic checkOutput(input string tag);
    total++;
    assert (o_valid === modelEmit) else begin
      bad++;
      $error("[TB] FAIL %s o_valid: got %b expected %b", tag, o_valid, modelEmit);
    end
    total++;
    assert (o_ready === modelReady) else begin
      bad++;
      $error("[TB] FAIL %s o_ready: got %b expected %b", tag, o_ready, modelReady);
    end
    if (modelEmit || dataIsZero) begin
      total++;
      assert (o_data === expData) else begin
        bad++;
        $error("[TB] FAIL %s o_data: got %h expected %h", tag, o_data, expData);
      end
      total++;
      assert (o_count === expCount) else begin
        bad++;
        $error("[TB] FAIL %s o_count: got %0d expected %0d", tag, o_count, expCount);
      end
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic valid,
                      input logic last, input logic [7:0] data);
    applyStimulus(rst, valid, last, data);
    checkOutput(tag);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    modelEmit  = 1'b0;
    modelReady = 1'b1;
    dataIsZero = 1'b1;
    expData    = '0;
    expCount   = '0;
    i_rst      = 1'b1;
    i_valid    = 1'b0;
    i_last     = 1'b0;
    i_data     = 8'h00;

    // Reset held for two cycles, then released
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("reset");
    step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // Full frame, back to back
    for (int i = 0; i < N; i++) step("full", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    step("full_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // Short frame closed by i_last, with the next byte offered during EMIT
    step("short", 1'b0, 1'b1, 1'b0, 8'hA0);
    step("short", 1'b0, 1'b1, 1'b0, 8'hA1);
    step("short", 1'b0, 1'b1, 1'b1, 8'hA2);
    step("held_in_emit", 1'b0, 1'b1, 1'b0, 8'h55);
    total++;
    assert (o_valid === 1'b0 && o_ready === 1'b1) else begin
      bad++;
      $error("[TB] FAIL emit_exit: got valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
    end
    step("held_accept", 1'b0, 1'b1, 1'b0, 8'h55);
    for (int i = 1; i < N; i++) step("held_frame", 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    total++;
    assert (o_data[0] === 8'h55) else begin
      bad++;
      $error("[TB] FAIL held_slot0: got %h expected 55", o_data[0]);
    end
    step("held_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // Partial frame discarded by a mid-frame reset
    for (int i = 0; i < 5; i++) step("partial", 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step("mid_reset", 1'b1, 1'b1, 1'b0, 8'hEE);
    for (int i = 0; i < N; i++) step("post_reset", 1'b0, 1'b1, 1'b0, 8'(i));
    step("post_reset_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // Full frame with i_valid toggling
    for (int i = 0; i < N; i++) begin
      step("gappy", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
      step("gappy_gap", 1'b0, 1'b0, 1'b0, 8'hBB);
    end
    step("gappy_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // Last byte flagged on the N-th slot is still a full frame
    for (int i = 0; i < N; i++) step("last_full", 1'b0, 1'b1, (i == N-1), 8'(8'h20 + i));
    step("last_full_after", 1'b0, 1'b0, 1'b0, 8'h00);

    // Randomized stream with occasional resets
    for (int k = 0; k < 400; k++) begin
      step("random",
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2),
           8'($urandom));
    end
    step("final", 1'b0, 1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
